// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and constants for the SPI register transaction sequencer.
// Holds the FSM encoding, command-byte layout and burst counter limits.
package spi_reg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CMD   = 2'd1,
      ST_WRITE = 2'd2,
      ST_READ  = 2'd3
   } state_e;

   localparam int         CMD_RD_BIT        = 7;
   localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'h00;
   localparam logic [7:0] BURST_SAT         = 8'd255;

   // Data-byte counter that sticks at its ceiling instead of wrapping.
   function automatic logic [7:0] burst_inc(input logic [7:0] n);
      return (n == BURST_SAT) ? n : n + 8'd1;
   endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Bundle between the SPI byte engine / register file and the transaction sequencer.
// The slave modport is the sequencer; the master modport is the surrounding logic.
interface spi_reg_ctrl_if #(
   parameter int ADDR_W = 7
);
   logic              cs;
   logic              byte_done;
   logic [7:0]        rx_byte;
   logic [7:0]        tx_byte;
   logic              tx_load;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_data;
   logic              commit;
   logic              busy;
   logic [7:0]        burst_len;

   modport slave (
      input  cs, byte_done, rx_byte, rd_data,
      output tx_byte, tx_load, wr_en, wr_addr, wr_data,
             rd_en, rd_addr, commit, busy, burst_len
   );

   modport master (
      output cs, byte_done, rx_byte, rd_data,
      input  tx_byte, tx_load, wr_en, wr_addr, wr_data,
             rd_en, rd_addr, commit, busy, burst_len
   );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Chip-select frame sequencer: decodes the command byte, then streams register
// writes or prefetched register reads with an auto-incrementing address.
module spi_reg_ctrl
   import spi_reg_pkg::*;
#(
   parameter int         ADDR_W    = 7,
   parameter logic [7:0] IDLE_BYTE = DEFAULT_IDLE_BYTE
) (
   input  logic           clk,
   input  logic           reset,
   spi_reg_ctrl_if.slave  bus
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        tx_byte_q, tx_byte_d;
   logic              tx_load_q, tx_load_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              commit_q, commit_d;
   logic [7:0]        burst_len_q, burst_len_d;
   logic [ADDR_W-1:0] cmd_addr;

   assign cmd_addr = bus.rx_byte[ADDR_W-1:0];

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      tx_byte_d   = tx_byte_q;
      tx_load_d   = 1'b0;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      rd_en_d     = 1'b0;
      rd_addr_d   = rd_addr_q;
      commit_d    = 1'b0;
      burst_len_d = burst_len_q;

      case (state_q)
         ST_IDLE: begin
            if (!bus.cs) begin
               state_d     = ST_CMD;
               burst_len_d = 8'd0;
               tx_load_d   = 1'b1;
               tx_byte_d   = IDLE_BYTE;
            end
         end
         ST_CMD: begin
            if (bus.cs) begin
               state_d = ST_IDLE;
            end else if (bus.byte_done) begin
               if (bus.rx_byte[CMD_RD_BIT]) begin
                  state_d   = ST_READ;
                  rd_en_d   = 1'b1;
                  rd_addr_d = cmd_addr;
                  addr_d    = cmd_addr + ADDR_ONE;
               end else begin
                  state_d = ST_WRITE;
                  addr_d  = cmd_addr;
               end
            end
         end
         ST_WRITE: begin
            if (bus.cs) begin
               state_d  = ST_IDLE;
               commit_d = (burst_len_q != 8'd0);
            end else if (bus.byte_done) begin
               wr_en_d     = 1'b1;
               wr_addr_d   = addr_q;
               wr_data_d   = bus.rx_byte;
               addr_d      = addr_q + ADDR_ONE;
               burst_len_d = burst_inc(burst_len_q);
               tx_load_d   = 1'b1;
               tx_byte_d   = IDLE_BYTE;
            end
         end
         ST_READ: begin
            // cs high cancels both the pending load and any new prefetch.
            if (bus.cs) begin
               state_d = ST_IDLE;
            end else begin
               if (rd_en_q) begin
                  tx_load_d = 1'b1;
                  tx_byte_d = bus.rd_data;
               end
               if (bus.byte_done) begin
                  rd_en_d     = 1'b1;
                  rd_addr_d   = addr_q;
                  addr_d      = addr_q + ADDR_ONE;
                  burst_len_d = burst_inc(burst_len_q);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         tx_byte_q   <= IDLE_BYTE;
         tx_load_q   <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= 8'd0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         commit_q    <= 1'b0;
         burst_len_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         tx_byte_q   <= tx_byte_d;
         tx_load_q   <= tx_load_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         rd_en_q     <= rd_en_d;
         rd_addr_q   <= rd_addr_d;
         commit_q    <= commit_d;
         burst_len_q <= burst_len_d;
      end
   end

   assign bus.tx_byte   = tx_byte_q;
   assign bus.tx_load   = tx_load_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.rd_en     = rd_en_q;
   assign bus.rd_addr   = rd_addr_q;
   assign bus.commit    = commit_q;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.burst_len = burst_len_q;

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Transaction sequencer sitting on top of the SPI slave byte engine (bit counter plus shift register).
- Decodes the command byte of each chip-select frame, then drives a byte-wide register write port or register read port with auto-incrementing address.
- Supplies the next outgoing byte to the shift register's parallel-load port.
- Pulses commit at the end of any write frame so the miner core can latch new configuration.

Parameters:
ADDR_W, 7, register address width (1..7); addresses wrap modulo 2^ADDR_W.
IDLE_BYTE, 8'h00, byte loaded into tx_byte when no read data is due.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
cs  in  1  SPI chip select, active low, already synchronous to clk.
byte_done  in  1  one-clk pulse: rx_byte holds a complete received byte.
rx_byte  in  8  byte received from the shift register.
tx_byte  out  8  byte to parallel-load into the shift register.
tx_load  out  1  one-clk pulse: load tx_byte.
wr_en  out  1  one-clk register write strobe.
wr_addr  out  ADDR_W  write address.
wr_data  out  8  write data.
rd_en  out  1  one-clk register read strobe.
rd_addr  out  ADDR_W  read address.
rd_data  in  8  read data, combinational from rd_addr, sampled in the rd_en cycle.
commit  out  1  one-clk pulse at the end of a frame that wrote at least one byte.
busy  out  1  high while state != IDLE.
burst_len  out  8  count of data bytes in the current/last frame, saturating at 255.

Behaviour:
- Reset: state=IDLE, addr=0, tx_byte=IDLE_BYTE; tx_load, wr_en, rd_en, commit, busy = 0; wr_addr=0, wr_data=0, rd_addr=0; burst_len=0.
- Reset mid-frame aborts the frame: no wr_en, no commit.
- Command byte: bit7 = 1 means read, 0 means write; bits[ADDR_W-1:0] = start address; unused bits ignored.
- States: IDLE, CMD, WRITE, READ.
- IDLE -> CMD when cs=0. On entry: burst_len cleared, tx_load pulsed with IDLE_BYTE.
- CMD, on byte_done:
  - addr <= cmd address.
  - Write command -> WRITE.
  - Read command -> READ and start a prefetch.
- WRITE, byte_done in cycle N:
  - Cycle N+1: wr_en=1, wr_addr=addr, wr_data=rx_byte.
  - addr <= addr+1 (wrap); burst_len++ (saturating).
  - tx_load pulsed with IDLE_BYTE.
- READ prefetch, triggered by byte_done in cycle N (the command byte or any data byte):
  - Cycle N+1: rd_en=1, rd_addr=addr; rd_data captured.
  - Cycle N+2: tx_byte=captured data, tx_load=1.
  - addr <= addr+1 (wrap).
  - For data bytes, burst_len++; the rx_byte content is ignored.
- Read latency byte_done -> tx_load is 2 clk. This relies on clk being much faster than sclk so the load lands before the next byte's first shift.
- cs rising (0 -> 1) in any state:
  - Next cycle state=IDLE.
  - commit=1 for one clk iff the frame was WRITE with burst_len >= 1.
  - A partial byte is discarded.
  - A byte_done coincident with cs=1 is dropped (cs has priority).
  - A pending prefetch is cancelled: no rd_en/tx_load after cs=1 is sampled.
- byte_done while cs=1 or in IDLE: ignored.
- Address wrap: 2^ADDR_W-1 -> 0. No error flag.
- At most one of wr_en/rd_en is high per cycle; each strobe lasts exactly one clk.
- busy=1 in CMD/WRITE/READ; 0 in IDLE.
- burst_len holds its value after the frame until the next frame enters CMD.

Decomposition:
- Package spi_reg_pkg holds:
  - state encoding (IDLE, CMD, WRITE, READ);
  - CMD_RD_BIT=7;
  - default IDLE_BYTE;
  - the burst_len saturation value.
- Single module, no sub-module; the cs edge detect and prefetch pipeline are inline registers.

Test Plan:
- Reset mid-frame: write cmd 8'h05, reset asserted before the data byte -> no wr_en, no commit; all outputs at reset values; busy=0.
- Write burst: cs=0, bytes 8'h05, 8'hAA, 8'hBB, cs=1 -> wr_en at addr 5 data AA, then addr 6 data BB; commit pulses once; burst_len=2.
- Read burst: cmd 8'h83, rd_data model returns addr+8'h10, two dummy bytes -> rd_addr 3, 4, 5 issued; tx_byte 8'h13, 8'h14, 8'h15, each tx_load exactly 2 clk after the triggering byte_done.
- Wrap: ADDR_W=7, write cmd 8'h7F, three data bytes -> wr_addr sequence 127, 0, 1.
- Empty frame: write cmd only, then cs=1 -> no wr_en, commit stays 0, burst_len=0.
- Abort: read cmd with cs rising in the same cycle as byte_done -> state IDLE, no rd_en, no tx_load, no commit.
